// File: rtl/alarm_bank.sv
// alarm_bank: N independent alarm channels with snooze limit, ring timeout, missed flags and do-not-disturb
module alarm_bank #(
  parameter int N_ALARM = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_SEC = 60,
  localparam int IW = N_ALARM > 1 ? $clog2(N_ALARM) : 1,
  localparam int SW = MAX_SNOOZE > 0 ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sec_tick,
  input  logic [4:0]         cur_hour,
  input  logic [5:0]         cur_min,
  input  logic [5:0]         cur_sec,
  input  logic               dnd,
  input  logic               snooze_btn,
  input  logic               stop_btn,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_idx,
  input  logic [4:0]         wr_hour,
  input  logic [5:0]         wr_min,
  input  logic               wr_on,
  output logic               ring,
  output logic [IW-1:0]      ring_idx,
  output logic [N_ALARM-1:0] ring_mask,
  output logic [N_ALARM-1:0] snooze_mask,
  output logic [N_ALARM-1:0] missed
);
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
  state_t             state_q [N_ALARM], state_d [N_ALARM];
  logic [4:0]         hour_q [N_ALARM], hour_d [N_ALARM];
  logic [5:0]         min_q [N_ALARM], min_d [N_ALARM];
  logic [7:0]         ring_cnt_q [N_ALARM], ring_cnt_d [N_ALARM];
  logic [10:0]        snooze_cnt_q [N_ALARM], snooze_cnt_d [N_ALARM];
  logic [SW-1:0]      snz_used_q [N_ALARM], snz_used_d [N_ALARM];
  logic [N_ALARM-1:0] on_q, on_d, missed_q, missed_d;
  logic               wr_ok;
  always_comb begin
    wr_ok = wr_en && wr_hour <= 5'd23 && wr_min <= 6'd59 && int'(wr_idx) < N_ALARM;
    state_d = state_q;
    hour_d = hour_q;
    min_d = min_q;
    ring_cnt_d = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    snz_used_d = snz_used_q;
    on_d = on_q;
    missed_d = missed_q;
    for (int i = 0; i < N_ALARM; i++) begin
      if (wr_ok && int'(wr_idx) == i) begin
        hour_d[i] = wr_hour;
        min_d[i] = wr_min;
        on_d[i] = wr_on;
        state_d[i] = IDLE;
        ring_cnt_d[i] = '0;
        snooze_cnt_d[i] = '0;
        snz_used_d[i] = '0;
        missed_d[i] = 1'b0;
      end else begin
        if (stop_btn) missed_d[i] = 1'b0;
        if (state_q[i] == RINGING && (stop_btn || snooze_btn || dnd)) begin
          state_d[i] = IDLE;
          if (!stop_btn && snooze_btn && int'(snz_used_q[i]) < MAX_SNOOZE) begin
            state_d[i] = SNOOZE;
            snooze_cnt_d[i] = 11'(SNOOZE_MIN * 60 - 1);
            snz_used_d[i] = snz_used_q[i] + SW'(1);
          end
        end else if (sec_tick) begin
          if (state_q[i] == IDLE && on_q[i] && !dnd && cur_hour == hour_q[i] && cur_min == min_q[i] && cur_sec == 6'd0) begin
            state_d[i] = RINGING;
            ring_cnt_d[i] = '0;
            snz_used_d[i] = '0;
          end else if (state_q[i] == RINGING) begin
            if (ring_cnt_q[i] == 8'(RING_SEC - 1)) begin
              state_d[i] = IDLE;
              missed_d[i] = 1'b1;
            end else ring_cnt_d[i] = ring_cnt_q[i] + 8'd1;
          end else if (state_q[i] == SNOOZE) begin
            if (snooze_cnt_q[i] == 11'd0) begin
              state_d[i] = dnd ? IDLE : RINGING;
              ring_cnt_d[i] = '0;
            end else snooze_cnt_d[i] = snooze_cnt_q[i] - 11'd1;
          end
        end
      end
    end
  end
  always_comb begin
    ring_mask = '0;
    snooze_mask = '0;
    ring_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      ring_mask[i] = state_q[i] == RINGING;
      snooze_mask[i] = state_q[i] == SNOOZE;
      if (ring_mask[i]) ring_idx = IW'(i);
    end
    ring = |ring_mask && !dnd;
    missed = missed_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ALARM; i++) begin
        state_q[i] <= IDLE;
        hour_q[i] <= '0;
        min_q[i] <= '0;
        ring_cnt_q[i] <= '0;
        snooze_cnt_q[i] <= '0;
        snz_used_q[i] <= '0;
      end
      on_q <= '0;
      missed_q <= '0;
    end else begin
      state_q <= state_d;
      hour_q <= hour_d;
      min_q <= min_d;
      ring_cnt_q <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      snz_used_q <= snz_used_d;
      on_q <= on_d;
      missed_q <= missed_d;
    end
  end
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed plan plus random traffic against a countdown-based reference model
module tb_alarm_bank;
  localparam int N = 4, SNZ = 5, MAXS = 3, RS = 60;
  logic clk = 0, rst = 1, sec_tick = 0, dnd = 0, snooze_btn = 0, stop_btn = 0, wr_en = 0, wr_on = 0;
  logic [4:0] cur_hour = 0, wr_hour = 0;
  logic [5:0] cur_min = 0, cur_sec = 0, wr_min = 0;
  logic [1:0] wr_idx = 0;
  logic ring;
  logic [1:0] ring_idx;
  logic [N-1:0] ring_mask, snooze_mask, missed;
  int checks = 0, errors = 0;
  int m_hour [N], m_min [N], m_ring_left [N], m_snz_left [N], m_used [N];
  bit m_on [N];
  bit [N-1:0] m_missed;
  int ph [3] = '{6, 7, 8};
  int pm [3] = '{0, 30, 0};
  alarm_bank #(.N_ALARM(N), .SNOOZE_MIN(SNZ), .MAX_SNOOZE(MAXS), .RING_SEC(RS)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .dnd(dnd), .snooze_btn(snooze_btn), .stop_btn(stop_btn), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_hour(wr_hour), .wr_min(wr_min), .wr_on(wr_on), .ring(ring), .ring_idx(ring_idx),
    .ring_mask(ring_mask), .snooze_mask(snooze_mask), .missed(missed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step;
    bit wv;
    wv = wr_en && wr_hour <= 23 && wr_min <= 59;
    for (int i = 0; i < N; i++) begin
      if (rst || (wv && int'(wr_idx) == i)) begin
        m_hour[i] = rst ? 0 : int'(wr_hour);
        m_min[i] = rst ? 0 : int'(wr_min);
        m_on[i] = rst ? 1'b0 : wr_on;
        m_ring_left[i] = 0;
        m_snz_left[i] = 0;
        m_used[i] = 0;
        m_missed[i] = 0;
      end else begin
        if (stop_btn) m_missed[i] = 0;
        if (m_ring_left[i] > 0 && stop_btn) m_ring_left[i] = 0;
        else if (m_ring_left[i] > 0 && snooze_btn) begin
          m_ring_left[i] = 0;
          if (m_used[i] < MAXS) begin
            m_snz_left[i] = SNZ * 60;
            m_used[i]++;
          end
        end else if (m_ring_left[i] > 0 && dnd) m_ring_left[i] = 0;
        else if (sec_tick) begin
          if (m_ring_left[i] > 0) begin
            m_ring_left[i]--;
            if (m_ring_left[i] == 0) m_missed[i] = 1;
          end else if (m_snz_left[i] > 0) begin
            m_snz_left[i]--;
            if (m_snz_left[i] == 0 && !dnd) m_ring_left[i] = RS;
          end else if (m_on[i] && !dnd && int'(cur_hour) == m_hour[i] && int'(cur_min) == m_min[i] && cur_sec == 0) begin
            m_ring_left[i] = RS;
            m_used[i] = 0;
          end
        end
      end
    end
  endtask
  task automatic check_all;
    logic [N-1:0] rm, sm;
    logic [1:0] ri;
    ri = 0;
    for (int i = 0; i < N; i++) begin
      rm[i] = m_ring_left[i] > 0;
      sm[i] = m_snz_left[i] > 0;
    end
    for (int i = N - 1; i >= 0; i--) if (rm[i]) ri = 2'(i);
    chk("ring_mask", 32'(ring_mask), 32'(rm));
    chk("snooze_mask", 32'(snooze_mask), 32'(sm));
    chk("missed", 32'(missed), 32'(m_missed));
    chk("ring", 32'(ring), 32'(|rm && !dnd));
    chk("ring_idx", 32'(ring_idx), 32'(ri));
  endtask
  task automatic cyc;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic tick(input int n);
    cur_sec = 30;
    sec_tick = 1;
    repeat (n) cyc();
    sec_tick = 0;
  endtask
  task automatic at(input int h, input int m, input int s);
    cur_hour = 5'(h);
    cur_min = 6'(m);
    cur_sec = 6'(s);
    sec_tick = 1;
    cyc();
    sec_tick = 0;
  endtask
  task automatic wr(input int i, input int h, input int m, input bit o);
    wr_idx = 2'(i);
    wr_hour = 5'(h);
    wr_min = 6'(m);
    wr_on = o;
    wr_en = 1;
    cyc();
    wr_en = 0;
  endtask
  task automatic press(input bit s, input bit t);
    snooze_btn = s;
    stop_btn = t;
    cyc();
    snooze_btn = 0;
    stop_btn = 0;
  endtask
  initial begin
    cyc();
    rst = 0;
    chk("rst_outs", 32'({ring, ring_idx, ring_mask, snooze_mask, missed}), 0);
    wr(2, 7, 30, 1);
    at(7, 29, 59);
    chk("pre_trig", 32'(ring_mask), 0);
    at(7, 30, 0);
    chk("trig_mask", 32'(ring_mask), 32'h4);
    chk("trig_ring", 32'(ring), 1);
    chk("trig_idx", 32'(ring_idx), 2);
    for (int k = 0; k < 3; k++) begin
      press(1, 0);
      chk("snz_mask", 32'(snooze_mask), 32'h4);
      chk("snz_ring", 32'(ring), 0);
      tick(299);
      chk("snz_hold", 32'(snooze_mask), 32'h4);
      tick(1);
      chk("snz_rering", 32'(ring_mask), 32'h4);
    end
    press(1, 0);
    chk("snz_limit", 32'({ring, ring_mask, snooze_mask}), 0);
    wr(1, 8, 0, 1);
    at(8, 0, 0);
    chk("ch1_ring", 32'(ring_mask), 32'h2);
    tick(59);
    chk("ch1_59", 32'(ring_mask), 32'h2);
    tick(1);
    chk("ch1_timeout", 32'(ring_mask), 0);
    chk("ch1_missed", 32'(missed), 32'h2);
    press(0, 1);
    chk("stop_clr_missed", 32'(missed), 0);
    wr(0, 6, 0, 1);
    wr(3, 6, 0, 1);
    at(6, 0, 0);
    chk("dual_mask", 32'(ring_mask), 32'h9);
    chk("dual_idx", 32'(ring_idx), 0);
    press(0, 1);
    chk("dual_stop", 32'(ring_mask), 0);
    dnd = 1;
    at(6, 0, 0);
    chk("dnd_trig", 32'(ring_mask), 0);
    dnd = 0;
    at(7, 30, 0);
    chk("ch2_again", 32'(ring_mask), 32'h4);
    dnd = 1;
    cyc();
    chk("dnd_force", 32'({ring, ring_mask, missed}), 0);
    dnd = 0;
    at(7, 30, 0);
    press(1, 0);
    dnd = 1;
    tick(300);
    chk("dnd_snz_exp", 32'({ring_mask, snooze_mask}), 0);
    dnd = 0;
    wr(1, 9, 60, 1);
    at(8, 0, 0);
    chk("bad_wr_ignored", 32'(ring_mask), 32'h2);
    press(0, 1);
    wr_idx = 1; wr_hour = 8; wr_min = 0; wr_on = 1; wr_en = 1;
    at(8, 0, 0);
    wr_en = 0;
    chk("wr_beats_trig", 32'(ring_mask), 0);
    at(8, 0, 0);
    chk("ch1_retrig", 32'(ring_mask), 32'h2);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_mid_ring", 32'({ring, ring_idx, ring_mask, snooze_mask, missed}), 0);
    for (int c = 0; c < 5000; c++) begin
      int p;
      rst = $urandom_range(0, 999) == 0;
      sec_tick = 1'($urandom_range(0, 1));
      p = $urandom_range(0, 3);
      cur_hour = p < 3 ? 5'(ph[p]) : 5'($urandom_range(0, 23));
      cur_min = p < 3 ? 6'(pm[p]) : 6'($urandom_range(0, 59));
      cur_sec = $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 59)) : 6'd0;
      if ($urandom_range(0, 79) == 0) dnd = ~dnd;
      snooze_btn = $urandom_range(0, 29) == 0;
      stop_btn = $urandom_range(0, 69) == 0;
      wr_en = $urandom_range(0, 59) == 0;
      wr_idx = 2'($urandom_range(0, 3));
      p = $urandom_range(0, 2);
      wr_hour = $urandom_range(0, 9) == 0 ? 5'($urandom_range(24, 31)) : 5'(ph[p]);
      wr_min = $urandom_range(0, 9) == 0 ? 6'($urandom_range(60, 63)) : 6'(pm[p]);
      wr_on = $urandom_range(0, 3) != 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Parametrised successor to the single-alarm block: N independent alarm channels.
- Each channel has HH:MM, enable, snooze with a repeat limit, ring timeout, missed flag, and a global do-not-disturb input.
- Sits between current_time (hour/minute/second) and musicwake/music; ring drives the wake-music trigger.
- Advances on a one-cycle second tick from the divider, clocked on the system clock.

Parameters:
N_ALARM, 4, number of alarm channels (1..16)
SNOOZE_MIN, 5, snooze length in minutes (1..30)
MAX_SNOOZE, 3, snoozes allowed per trigger; a further snooze acts as stop
RING_SEC, 60, seconds a channel rings before auto-stop (1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
sec_tick  in  1  one-cycle pulse, once per second
cur_hour  in  5  current hour 0..23
cur_min  in  6  current minute 0..59
cur_sec  in  6  current second 0..59
dnd  in  1  do-not-disturb (switch)
snooze_btn  in  1  one-cycle pulse (debounced upstream)
stop_btn  in  1  one-cycle pulse
wr_en  in  1  configuration write strobe
wr_idx  in  clog2(N_ALARM) (min 1)  channel written
wr_hour  in  5  alarm hour
wr_min  in  6  alarm minute
wr_on  in  1  channel enable
ring  out  1  any channel ringing
ring_idx  out  clog2(N_ALARM) (min 1)  lowest-index ringing channel, 0 if none
ring_mask  out  N_ALARM  per-channel RINGING
snooze_mask  out  N_ALARM  per-channel SNOOZE
missed  out  N_ALARM  sticky: ring timed out unanswered

Behaviour:
- Reset (sync, rst=1 at posedge): all channels IDLE, times 00:00, disabled; counters 0; all outputs 0.
- Per-channel state: hour, min, on, state{IDLE,RINGING,SNOOZE}, ring_cnt (8b), snooze_cnt (11b, seconds), snz_used (clog2(MAX_SNOOZE+1)b).
- Outputs are decoded directly from the state registers; they change the cycle after the causing edge.
- Trigger: state IDLE, on=1, dnd=0, sec_tick=1, cur_hour==hour, cur_min==min, cur_sec==0 -> RINGING, ring_cnt=0, snz_used=0.
  - With dnd=1 at that instant the trigger is lost, not deferred.
- RINGING:
  - each sec_tick increments ring_cnt;
  - when ring_cnt==RING_SEC-1 and sec_tick -> IDLE, missed[i]=1.
- Buttons act on every channel currently in RINGING:
  - stop_btn -> IDLE.
  - snooze_btn with snz_used<MAX_SNOOZE -> SNOOZE, snooze_cnt=SNOOZE_MIN*60-1, snz_used+1.
  - snooze_btn with snz_used==MAX_SNOOZE -> IDLE (treated as stop).
  - Buttons while no channel rings have no effect except that stop_btn clears all missed bits.
  - stop_btn always clears all missed bits.
- SNOOZE:
  - each sec_tick decrements snooze_cnt;
  - at snooze_cnt==0 with sec_tick -> RINGING, ring_cnt=0 (snz_used kept);
  - buttons ignored.
- dnd:
  - while dnd=1, every RINGING channel is forced to IDLE on the next edge (missed not set);
  - SNOOZE channels keep counting, and re-enter RINGING only if dnd=0 at expiry, else IDLE;
  - ring is always masked by dnd.
- Config write (wr_en): loads hour/min/on of wr_idx, forces that channel IDLE, clears its counters and missed bit.
  - wr_hour>23 or wr_min>59: write ignored entirely.
  - wr_idx>=N_ALARM: ignored.
- Same-cycle priority per channel, highest first: rst, valid write, stop_btn, snooze_btn, dnd force, sec_tick-driven transition.
  - Example: a write coinciding with the trigger tick yields IDLE with the new time, no ring.
  - Example: snooze and timeout in the same cycle -> SNOOZE, missed not set.
- Channels are fully independent; multiple may ring together; ring_idx is the lowest set bit of ring_mask.
- Disabling (on=0) via a write stops a ringing/snoozing channel.

Test Plan:
- Reset, then write ch2=07:30 on; drive cur=07:29:59 tick, then 07:30:00 tick -> ring_mask=0100, ring=1, ring_idx=2 the cycle after the second tick; ch0 stays IDLE.
- Ch2 ringing, snooze_btn -> snooze_mask=0100, ring=0; 300 ticks later (SNOOZE_MIN=5) -> ring_mask=0100 again.
  - Repeat to 3 snoozes; the 4th snooze_btn -> IDLE, all masks 0.
- Ch1 ringing, no buttons, 60 ticks -> ring_mask bit1 clears exactly on the 60th tick, missed=0010.
  - stop_btn -> missed=0000.
- Ch0 and ch3 both at 06:00, trigger -> ring_mask=1001, ring_idx=0; stop_btn -> both IDLE.
- dnd=1 at trigger -> no ring.
  - Set dnd=1 while ch2 is ringing -> ring=0 next cycle and ch2 IDLE, missed=0.
  - Set dnd=1 while ch2 is snoozing -> at expiry ch2 goes IDLE, no ring.
- Write ch1 with wr_min=60 -> configuration unchanged.
  - Write to ch1 on the same cycle as its trigger tick -> no ring.
  - rst mid-RINGING -> all outputs 0 next cycle.
